// File: rtl/mul_pkg.sv
// mul_pkg: shared constants and helpers for the pipelined multiplier.
// Callers use mul_lat() to size tag/timing logic around mul_pipe_sat.
package mul_pkg;

  // Result width of the default motor-control build.
  localparam int MUL_W = 32;

  // W-bit result range bounds for the default width.
  localparam logic [MUL_W-1:0] MUL_SMAX =
    {1'b0, {(MUL_W-1){1'b1}}};
  localparam logic [MUL_W-1:0] MUL_SMIN =
    {1'b1, {(MUL_W-1){1'b0}}};
  localparam logic [MUL_W-1:0] MUL_UMAX =
    {MUL_W{1'b1}};

  // Input reg + product regs + round/sat reg.
  function automatic int mul_lat(input int mul_stages);
    return mul_stages + 2;
  endfunction

endpackage

// File: rtl/pipe_dly.sv
// pipe_dly: async-reset, sync-clear shift line carrying valid + data.
// Ports: c, rst, clear, valid_i/data_i in; valid_o/data_o out,
// pre_valid_o = valid of the entry that becomes the output next edge.
module pipe_dly #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
) (
  input  logic             c,
  input  logic             rst,
  input  logic             clear,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             pre_valid_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [WIDTH-1:0] dat_q [DEPTH];
  logic [WIDTH-1:0] dat_d [DEPTH];

  // Data only moves with a valid entry, so the tail
  // holds the last delivered value across bubbles.
  always_comb begin
    vld_d = clear ? '0 : {vld_q[DEPTH-2:0], valid_i};
    dat_d[0] = (valid_i && !clear) ? data_i : dat_q[0];
    for (int i = 1; i < DEPTH; i++) begin
      dat_d[i] = (vld_q[i-1] && !clear) ?
                 dat_q[i-1] : dat_q[i];
    end
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign valid_o     = vld_q[DEPTH-1];
  assign data_o      = dat_q[DEPTH-1];
  assign pre_valid_o = vld_q[DEPTH-2];

endmodule

// File: rtl/mul_pipe_sat.sv
// mul_pipe_sat: pipelined fixed-point multiply, round-half-up, saturate.
// Ports: c, rst, clear, in_valid, a, b, in_tag -> out_valid, q, sat, out_tag.
module mul_pipe_sat
  import mul_pkg::*;
#(
  parameter int W          = 32,
  parameter int SIGNED     = 1,
  parameter int SHIFT      = 0,
  parameter int MUL_STAGES = 3,
  parameter int TAG_W      = 4
) (
  input  logic             c,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [W-1:0]     q,
  output logic             sat,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW  = 2 * W;
  localparam int RW  = PW + 1;
  localparam int LAT = mul_lat(MUL_STAGES);
  localparam int BSH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [RW-1:0] BIAS =
    (SHIFT > 0) ? (RW'(1) << BSH) : '0;
  localparam logic signed [RW-1:0] SMAX_R =
    (RW'(1) << (W-1)) - RW'(1);
  localparam logic signed [RW-1:0] SMIN_R =
    -(RW'(1) << (W-1));
  localparam logic [RW-1:0] UMAX_R =
    (RW'(1) << W) - RW'(1);

  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0] prod_q [MUL_STAGES];
  logic [PW-1:0] prod_d [MUL_STAGES];
  logic [W-1:0]  q_q, q_d;
  logic          sat_q, sat_d;

  logic          pre_valid;
  logic          fa, fb, fp;
  logic [PW-1:0] a_x, b_x;
  logic [RW-1:0] sum, rnd_u;
  logic signed [RW-1:0] rnd_s;

  pipe_dly #(
    .WIDTH(TAG_W),
    .DEPTH(LAT)
  ) u_dly (
    .c          (c),
    .rst        (rst),
    .clear      (clear),
    .valid_i    (in_valid),
    .data_i     (in_tag),
    .valid_o    (out_valid),
    .data_o     (out_tag),
    .pre_valid_o(pre_valid)
  );

  // Operand extension to 2W makes the low 2W
  // product bits correct for both signednesses.
  always_comb begin
    a_d = a;
    b_d = b;
    fa  = (SIGNED != 0) && a_q[W-1];
    fb  = (SIGNED != 0) && b_q[W-1];
    a_x = {{W{fa}}, a_q};
    b_x = {{W{fb}}, b_q};
    prod_d[0] = a_x * b_x;
    for (int i = 1; i < MUL_STAGES; i++) begin
      prod_d[i] = prod_q[i-1];
    end
  end

  // One spare bit keeps (-2^(W-1))^2 + bias
  // from wrapping into the sign.
  always_comb begin
    fp    = (SIGNED != 0) && prod_q[MUL_STAGES-1][PW-1];
    sum   = {fp, prod_q[MUL_STAGES-1]} + BIAS;
    rnd_s = $signed(sum) >>> SHIFT;
    rnd_u = sum >> SHIFT;
    q_d   = q_q;
    sat_d = sat_q;
    if (pre_valid && !clear) begin
      sat_d = 1'b0;
      if (SIGNED != 0) begin
        q_d = rnd_s[W-1:0];
        if (rnd_s > SMAX_R) begin
          q_d   = SMAX_R[W-1:0];
          sat_d = 1'b1;
        end else if (rnd_s < SMIN_R) begin
          q_d   = SMIN_R[W-1:0];
          sat_d = 1'b1;
        end
      end else begin
        q_d = rnd_u[W-1:0];
        if (rnd_u > UMAX_R) begin
          q_d   = UMAX_R[W-1:0];
          sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      q_q   <= '0;
      sat_q <= 1'b0;
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= '0;
      end
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      q_q   <= q_d;
      sat_q <= sat_d;
      for (int i = 0; i < MUL_STAGES; i++) begin
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign q   = q_q;
  assign sat = sat_q;

endmodule

// File: tb/tb_mul_pipe_sat.sv
// tb_mul_pipe_sat: scoreboard bench for three multiplier configurations.
// Stimulus pushes expectations; per-instance monitors pop and compare.
module tb_mul_pipe_sat;

  localparam int LAT = 5;

  typedef struct {
    logic [31:0] q;
    logic        sat;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] q;
    logic        sat;
  } vec_t;

  logic c = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;

  logic        iv0 = 0, iv1 = 0, iv2 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [15:0] a2 = 0, b2 = 0;
  logic [3:0]  tg0 = 0, tg1 = 0, tg2 = 0;
  logic        ov0, ov1, ov2, s0, s1, s2;
  logic [31:0] q0, q1;
  logic [15:0] q2;
  logic [3:0]  t0, t1, t2;

  int   cyc = 0;
  int   ntest = 0;
  int   nfail = 0;
  int   pulses [3] = '{0, 0, 0};
  exp_t sb [3][$];

  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  mul_pipe_sat #(.W(32), .SIGNED(1), .SHIFT(0),
    .MUL_STAGES(3), .TAG_W(4)) u0 (
    .c(c), .rst(rst), .clear(clear), .in_valid(iv0),
    .a(a0), .b(b0), .in_tag(tg0), .out_valid(ov0),
    .q(q0), .sat(s0), .out_tag(t0));

  mul_pipe_sat #(.W(32), .SIGNED(1), .SHIFT(16),
    .MUL_STAGES(3), .TAG_W(4)) u1 (
    .c(c), .rst(rst), .clear(clear), .in_valid(iv1),
    .a(a1), .b(b1), .in_tag(tg1), .out_valid(ov1),
    .q(q1), .sat(s1), .out_tag(t1));

  mul_pipe_sat #(.W(16), .SIGNED(0), .SHIFT(0),
    .MUL_STAGES(3), .TAG_W(4)) u2 (
    .c(c), .rst(rst), .clear(clear), .in_valid(iv2),
    .a(a2), .b(b2), .in_tag(tg2), .out_valid(ov2),
    .q(q2), .sat(s2), .out_tag(t2));

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntest++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic [31:0] qa,
                     input logic sa, input logic [3:0] ta);
    exp_t e;
    pulses[k]++;
    if (sb[k].size() == 0) begin
      ntest++;
      nfail++;
      $display("FAIL spurious_valid%0d: out_valid=1 at cycle %0d, required 0",
               k, cyc);
    end else begin
      e = sb[k].pop_front();
      chk($sformatf("q%0d_tag%0h", k, e.tag), qa, e.q);
      chk($sformatf("sat%0d_tag%0h", k, e.tag),
          {31'b0, sa}, {31'b0, e.sat});
      chk($sformatf("tag%0d", k), {28'b0, ta}, {28'b0, e.tag});
      chk($sformatf("cycle%0d_tag%0h", k, e.tag), cyc, e.cyc);
    end
  endtask

  always @(negedge c) if (ov0) mon(0, q0, s0, t0);
  always @(negedge c) if (ov1) mon(1, q1, s1, t1);
  always @(negedge c) if (ov2) mon(2, {16'b0, q2}, s2, t2);

  task automatic tick();
    @(negedge c);
    #1;
  endtask

  task automatic issue(input int k, input vec_t v, input bit trk);
    exp_t e;
    case (k)
      0: begin iv0 = 1; a0 = v.a; b0 = v.b; tg0 = v.tag; end
      1: begin iv1 = 1; a1 = v.a; b1 = v.b; tg1 = v.tag; end
      default: begin
        iv2 = 1; a2 = v.a[15:0]; b2 = v.b[15:0]; tg2 = v.tag;
      end
    endcase
    if (trk) begin
      e.q   = v.q;
      e.sat = v.sat;
      e.tag = v.tag;
      e.cyc = cyc + LAT;
      sb[k].push_back(e);
    end
    tick();
    iv0 = 0;
    iv1 = 0;
    iv2 = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (sb[0].size() + sb[1].size() + sb[2].size() == 0) break;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("drain%0d_pending", k), sb[k].size(), 0);
    end
  endtask

  vec_t t2v [8] = '{
    '{0, 1, 0, 0, 0},  '{1, 2, 1, 2, 0},
    '{2, 3, 2, 6, 0},  '{3, 4, 3, 12, 0},
    '{4, 5, 4, 20, 0}, '{5, 6, 5, 30, 0},
    '{6, 7, 6, 42, 0}, '{7, 8, 7, 56, 0}};

  vec_t tbub [4] = '{
    '{1, 3, 8, 3, 0},  '{2, 3, 9, 6, 0},
    '{3, 3, 10, 9, 0}, '{4, 3, 11, 12, 0}};

  vec_t t3v [6] = '{
    '{32'h7FFFFFFF, 2, 4'hA, 32'h7FFFFFFF, 1},
    '{32'h80000000, 32'h80000000, 4'hB, 32'h7FFFFFFF, 1},
    '{32'h80000000, 2, 4'hC, 32'h80000000, 1},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'hE, 1, 0},
    '{32'h7FFFFFFF, 1, 4'hF, 32'h7FFFFFFF, 0},
    '{32'h80000000, 1, 4'hD, 32'h80000000, 0}};

  vec_t t4v [6] = '{
    '{1, 32'h8000, 1, 1, 0},
    '{32'hFFFFFFFF, 32'h8000, 2, 0, 0},
    '{32'h00018000, 32'h00020000, 3, 32'h00030000, 0},
    '{32'hFFFFFFFD, 32'h8000, 4, 32'hFFFFFFFF, 0},
    '{32'h7FFFFFFF, 32'h7FFFFFFF, 5, 32'h7FFFFFFF, 1},
    '{32'h80000000, 32'h7FFFFFFF, 6, 32'h80000000, 1}};

  vec_t t5v [4] = '{
    '{16'hFFFF, 16'h0002, 1, 16'hFFFF, 1},
    '{16'h00FF, 16'h0101, 2, 16'hFFFF, 0},
    '{16'h0000, 16'hFFFF, 3, 16'h0000, 0},
    '{16'h0100, 16'h0100, 4, 16'hFFFF, 1}};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p;
    int xc;
    vec_t v;
    #2;
    chk("rst_out_valid", {31'b0, ov0}, 0);
    chk("rst_q", q0, 0);
    chk("rst_sat", {31'b0, s0}, 0);
    chk("rst_tag", {28'b0, t0}, 0);
    chk("rst_q_u16", {16'b0, q2}, 0);
    tick();
    tick();
    rst = 0;
    tick();

    p = pulses[0];
    v = '{32'd3, 32'hFFFFFFFC, 4'd5, 32'hFFFFFFF4, 1'b0};
    issue(0, v, 1);
    for (int i = 0; i < LAT + 2; i++) tick();
    chk("single_pulse_count", pulses[0] - p, 1);

    for (int i = 0; i < 8; i++) issue(0, t2v[i], 1);
    for (int i = 0; i < 4; i++) begin
      issue(0, tbub[i], 1);
      tick();
    end
    for (int i = 0; i < 6; i++) issue(0, t3v[i], 1);
    for (int i = 0; i < 6; i++) issue(1, t4v[i], 1);
    for (int i = 0; i < 4; i++) issue(2, t5v[i], 1);
    drain();

    p = pulses[0];
    v = '{32'd5, 32'd5, 4'h1, 32'd0, 1'b0};
    for (int i = 0; i < 3; i++) issue(0, v, 0);
    tick();
    clear = 1;
    issue(0, v, 0);
    clear = 0;
    for (int i = 0; i < LAT + 3; i++) tick();
    chk("clear_no_valid", pulses[0] - p, 0);
    chk("clear_hold_q", q0, 32'h80000000);
    chk("clear_hold_sat", {31'b0, s0}, 0);
    chk("clear_hold_tag", {28'b0, t0}, 32'hD);

    v = '{32'h7FFFFFFF, 32'd2, 4'h9, 32'h7FFFFFFF, 1'b1};
    xc = cyc + LAT;
    issue(0, v, 1);
    v = '{32'd7, 32'd7, 4'h3, 32'd49, 1'b0};
    issue(0, v, 0);
    issue(0, v, 0);
    for (int n = 0; n < 20 && cyc < xc; n++) tick();
    chk("pre_rst_valid", {31'b0, ov0}, 1);
    #1 rst = 1;
    #1;
    chk("async_rst_valid", {31'b0, ov0}, 0);
    chk("async_rst_q", q0, 0);
    chk("async_rst_sat", {31'b0, s0}, 0);
    chk("async_rst_tag", {28'b0, t0}, 0);
    tick();
    tick();
    rst = 0;
    p = pulses[0];
    for (int i = 0; i < LAT + 2; i++) tick();
    chk("post_rst_no_valid", pulses[0] - p, 0);
    v = '{32'd2, 32'd5, 4'h6, 32'd10, 1'b0};
    issue(0, v, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
